// File: rtl/seq_sub256bits.sv
// Multi-cycle n-bit subtractor computing d = a - b - bin one m-bit chunk per cycle.
// Optional zero/overflow flags are compiled in when SEQ_SUB_FLAGS_EN is defined.
module seq_sub256bits #(
    parameter int n = 256,
    parameter int m = 64
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         bin,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n-1:0] d,
    output logic         bout,
    output logic         out_valid,
    input  logic         out_ready
`ifdef SEQ_SUB_FLAGS_EN
    ,
    output logic         zf,
    output logic         ovf
`endif
);

    localparam int CHUNKS = n / m;
    localparam int IW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    if ((n % m) != 0 || CHUNKS < 2) begin : g_bad_params
        $error("seq_sub256bits: n must be a multiple of m with n/m >= 2");
    end

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t        state, state_next;
    logic [IW-1:0] idx;
    logic          carry;
    logic          ready_en;
    logic [n-1:0]  a_q;
    logic [n-1:0]  b_q;

    logic          accept;
    logic          last_chunk;
    int            base;
    logic [m-1:0]  a_chunk;
    logic [m-1:0]  b_chunk;
    logic [m:0]    chunk_sum;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: the default assignment at the top keeps every path assigned,
    // which is what prevents a latch from being inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CALC;
            CALC:    if (last_chunk) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: in_ready is held low until the first edge after reset release
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = (state == IDLE) && ready_en;
        out_valid = (state == DONE);
    end

    assign accept     = in_ready && in_valid;
    assign last_chunk = (idx == IW'(CHUNKS - 1));

    // ------------------------------------------------------------------
    // Chunk adder: a_k + ~b_k + carry, carry seeded with ~bin
    // ------------------------------------------------------------------
    always_comb begin
        base      = int'(idx) * m;
        a_chunk   = a_q[base +: m];
        b_chunk   = b_q[base +: m];
        chunk_sum = {1'b0, a_chunk} + {1'b0, ~b_chunk} + {{m{1'b0}}, carry};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx   <= '0;
            carry <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            d     <= '0;
            bout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q   <= a;
                        b_q   <= b;
                        carry <= ~bin;
                        idx   <= '0;
                    end
                end
                CALC: begin
                    d[base +: m] <= chunk_sum[m-1:0];
                    carry        <= chunk_sum[m];
                    if (last_chunk) begin
                        bout <= ~chunk_sum[m];
                        idx  <= '0;
                    end else begin
                        idx  <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SEQ_SUB_FLAGS_EN
    // Zero detection accumulates per chunk so the full-width compare is never needed.
    logic zero_acc;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            zero_acc <= 1'b0;
            zf       <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) zero_acc <= 1'b1;
                end
                CALC: begin
                    zero_acc <= zero_acc && (chunk_sum[m-1:0] == '0);
                    if (last_chunk) begin
                        zf  <= zero_acc && (chunk_sum[m-1:0] == '0);
                        // Overflow when a and ~b share a sign but the result sign differs.
                        ovf <= (a_q[n-1] == ~b_q[n-1]) && (chunk_sum[m-1] != a_q[n-1]);
                    end
                end
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_seq_sub256bits.sv
// Directed self-checking bench for seq_sub256bits at default parameters (n=256, m=64).
// Flag outputs are checked only when SEQ_SUB_FLAGS_EN is defined.
module tb_seq_sub256bits;

    localparam int N      = 256;
    localparam int CHUNKS = 4;

    logic         clk;
    logic         rstn;
    logic         in_valid;
    logic         in_ready;
    logic         bin;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] d;
    logic         bout;
    logic         out_valid;
    logic         out_ready;
`ifdef SEQ_SUB_FLAGS_EN
    logic         zf;
    logic         ovf;
`endif

    int total = 0;
    int bad   = 0;

    seq_sub256bits #(.n(256), .m(64)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin       (bin),
        .a         (a),
        .b         (b),
        .d         (d),
        .bout      (bout),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef SEQ_SUB_FLAGS_EN
        ,
        .zf        (zf),
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; optionally stalls in DONE while offering new operands.
    task automatic do_op(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                         input logic tbin, input logic [N-1:0] exp_d, input logic exp_bout,
                         input logic exp_zf, input logic exp_ovf, input int hold);
        int waited;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        check({tag, ".in_ready"}, N'(in_ready), N'(1));
        a        = ta;
        b        = tb_v;
        bin      = tbin;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, ".calc_in_ready"}, N'(in_ready), N'(0));
        for (int i = 1; i <= CHUNKS; i++) begin
            tick();
            if (i == CHUNKS - 1) check({tag, ".early_valid"}, N'(out_valid), N'(0));
        end
        check({tag, ".out_valid"}, N'(out_valid), N'(1));
        check({tag, ".d"}, d, exp_d);
        check({tag, ".bout"}, N'(bout), N'(exp_bout));
`ifdef SEQ_SUB_FLAGS_EN
        check({tag, ".zf"}, N'(zf), N'(exp_zf));
        check({tag, ".ovf"}, N'(ovf), N'(exp_ovf));
`else
        if (exp_zf === 1'bx || exp_ovf === 1'bx) $display("note: flag expectation unset for %s", tag);
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a        = {8{$urandom()}};
            b        = {8{$urandom()}};
            bin      = 1'($urandom_range(0, 1));
            tick();
            check({tag, ".hold_d"}, d, exp_d);
            check({tag, ".hold_in_ready"}, N'(in_ready), N'(0));
            check({tag, ".hold_valid"}, N'(out_valid), N'(1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".post_valid"}, N'(out_valid), N'(0));
        check({tag, ".post_in_ready"}, N'(in_ready), N'(1));
        check({tag, ".post_d"}, d, exp_d);
    endtask

    logic [N-1:0] ones;
    logic [N-1:0] p64;
    logic [N-1:0] p255;
    logic [N-1:0] p128;

    initial begin
        ones = '1;
        p64  = '0;
        p64[64] = 1'b1;
        p128 = '0;
        p128[128] = 1'b1;
        p255 = '0;
        p255[255] = 1'b1;

        rstn      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        bin       = 1'b0;
        a         = '0;
        b         = '0;
        #22;
        check("rst.in_ready", N'(in_ready), N'(0));
        check("rst.out_valid", N'(out_valid), N'(0));
        check("rst.d", d, '0);
        check("rst.bout", N'(bout), N'(0));
        @(negedge clk);
        rstn = 1'b1;
        check("rel.in_ready_low", N'(in_ready), N'(0));
        tick();
        check("rel.in_ready_first_edge", N'(in_ready), N'(1));

        do_op("zero_minus_one", '0, N'(1), 1'b0, ones, 1'b1, 1'b0, 1'b0, 0);
        do_op("ones_bin1", ones, ones, 1'b1, ones, 1'b1, 1'b0, 1'b0, 0);
        do_op("ones_bin0", ones, ones, 1'b0, '0, 1'b0, 1'b1, 1'b0, 0);
        do_op("chunk_ripple", p64, N'(1), 1'b0, p64 - N'(1), 1'b0, 1'b0, 1'b0, 0);
        do_op("signed_min", p255, N'(1), 1'b0, p255 - N'(1), 1'b0, 1'b0, 1'b1, 0);
        do_op("small_bin", N'(5), N'(3), 1'b1, N'(1), 1'b0, 1'b0, 1'b0, 0);
        do_op("hold_done", p128, '0, 1'b1, p128 - N'(1), 1'b0, 1'b0, 1'b0, 10);

        // Abort mid-calculation, then confirm a clean operation afterwards.
        a        = N'(7);
        b        = N'(2);
        bin      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        @(posedge clk);
        rstn = 1'b0;
        #1;
        check("abort.out_valid", N'(out_valid), N'(0));
        check("abort.in_ready", N'(in_ready), N'(0));
        check("abort.d", d, '0);
        check("abort.bout", N'(bout), N'(0));
        for (int i = 0; i < 6; i++) tick();
        check("abort.no_result", N'(out_valid), N'(0));
        @(negedge clk);
        rstn = 1'b1;
        tick();
        check("abort.in_ready_back", N'(in_ready), N'(1));
        do_op("after_abort", N'(0), N'(1), 1'b0, ones, 1'b1, 1'b0, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
